stopwatch_top: RTL and testbench

Top level of the MM:SS stopwatch. It holds a 1 Hz minutes/seconds counter with pause, and an adjust mode in which minutes or seconds advance at 2 Hz. It also multiplexes the four BCD digits onto a 4-digit common-anode 7-segment display. All dividers are parameterised so simulation can use short periods.

---
 rtl/stopwatch_top.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_stopwatch_top.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_top.sv
`timescale 1ns/1ps
// Purpose: MM:SS stopwatch with pause, 2 Hz minute/second adjust and a
//          multiplexed 4-digit common-anode 7-segment display driver.
// Latency: count digits update on the tick edge; pause acts 3 cycles after the
//          input edge, adj/sel 2 cycles after; seg/dig are registered together.
// Backpressure: none; every input is sampled on every clock.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high, clears all state
//   pause          pushbutton; each synchronized rising edge toggles run/hold
//   adj            switch, 1 = adjust mode
//   sel            switch, adjust target (0 = minutes, 1 = seconds)
//   min1/min2      minutes tens (0-5) / ones (0-9)
//   sec1/sec2      seconds tens (0-5) / ones (0-9)
//   seg            active-low segments, seg[0]=a .. seg[6]=g
//   dig            active-low anodes, dig[3]=min1 .. dig[0]=sec2

// Free-running divider that raises tick_o for one cycle every DIV cycles.
// The first tick arrives DIV cycles after reset is released.
module stopwatch_tick #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

module stopwatch_top #(
  parameter int ONE_HZ_DIV = 100_000_000,
  parameter int TWO_HZ_DIV = 50_000_000,
  parameter int SCAN_DIV   = 200_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] min1,
  output logic [3:0] min2,
  output logic [2:0] sec1,
  output logic [3:0] sec2,
  output logic [6:0] seg,
  output logic [3:0] dig
);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [1:0] pause_sync_q;
  logic [1:0] adj_sync_q;
  logic [1:0] sel_sync_q;
  logic       pause_dly_q;   // previous synchronized pause, for edge detect

  logic pause_s;
  logic adj_s;
  logic sel_s;
  logic pause_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause_sync_q <= '0;
      adj_sync_q   <= '0;
      sel_sync_q   <= '0;
      pause_dly_q  <= 1'b0;
    end else begin
      pause_sync_q <= {pause_sync_q[0], pause};
      adj_sync_q   <= {adj_sync_q[0], adj};
      sel_sync_q   <= {sel_sync_q[0], sel};
      pause_dly_q  <= pause_sync_q[1];
    end
  end

  assign pause_s    = pause_sync_q[1];
  assign adj_s      = adj_sync_q[1];
  assign sel_s      = sel_sync_q[1];
  // A held button produces a single pulse: only the 0->1 transition counts.
  assign pause_rise = pause_s & ~pause_dly_q;

  // ---------------------------------------------------------------------------
  // Tick generators; never reset by mode changes
  // ---------------------------------------------------------------------------
  logic tick_1hz;
  logic tick_2hz;
  logic tick_scan;
  logic tick_blink;

  stopwatch_tick #(.DIV(ONE_HZ_DIV)) u_tick_1hz (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick_1hz)
  );

  stopwatch_tick #(.DIV(TWO_HZ_DIV)) u_tick_2hz (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick_2hz)
  );

  stopwatch_tick #(.DIV(SCAN_DIV)) u_tick_scan (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick_scan)
  );

  stopwatch_tick #(.DIV(BLINK_DIV)) u_tick_blink (
    .clk_i  (clk),
    .rst_i  (reset),
    .tick_o (tick_blink)
  );

  // ---------------------------------------------------------------------------
  // Run/hold state. Pause edges toggle it even in adjust mode; it only gates
  // counting once adj returns to 0.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } run_state_e;

  run_state_e state_q;
  run_state_e state_d;
  logic       paused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pause_rise) begin
      state_d = (state_q == ST_RUN) ? ST_HOLD : ST_RUN;
    end
  end

  // Counting below looks at state_q, so a tick coinciding with the toggle
  // still sees the pre-toggle state.
  assign paused = (state_q == ST_HOLD);

  // ---------------------------------------------------------------------------
  // Time digits
  // ---------------------------------------------------------------------------
  logic [2:0] min1_q, min1_d;
  logic [3:0] min2_q, min2_d;
  logic [2:0] sec1_q, sec1_d;
  logic [3:0] sec2_q, sec2_d;

  logic count_en;
  logic adjust_en;

  assign count_en  = ~adj_s & ~paused & tick_1hz;
  assign adjust_en = adj_s & tick_2hz;

  always_comb begin
    min1_d = min1_q;
    min2_d = min2_q;
    sec1_d = sec1_q;
    sec2_d = sec2_q;

    if (count_en) begin
      // Full carry chain 00:00 .. 59:59 -> 00:00
      if (sec2_q == 4'd9) begin
        sec2_d = 4'd0;
        if (sec1_q == 3'd5) begin
          sec1_d = 3'd0;
          if (min2_q == 4'd9) begin
            min2_d = 4'd0;
            min1_d = (min1_q == 3'd5) ? 3'd0 : min1_q + 3'd1;
          end else begin
            min2_d = min2_q + 4'd1;
          end
        end else begin
          sec1_d = sec1_q + 3'd1;
        end
      end else begin
        sec2_d = sec2_q + 4'd1;
      end
    end else if (adjust_en) begin
      // Adjust advances only the selected pair; no carry between pairs.
      if (sel_s) begin
        if (sec2_q == 4'd9) begin
          sec2_d = 4'd0;
          sec1_d = (sec1_q == 3'd5) ? 3'd0 : sec1_q + 3'd1;
        end else begin
          sec2_d = sec2_q + 4'd1;
        end
      end else begin
        if (min2_q == 4'd9) begin
          min2_d = 4'd0;
          min1_d = (min1_q == 3'd5) ? 3'd0 : min1_q + 3'd1;
        end else begin
          min2_d = min2_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min1_q <= '0;
      min2_q <= '0;
      sec1_q <= '0;
      sec2_q <= '0;
    end else begin
      min1_q <= min1_d;
      min2_q <= min2_d;
      sec1_q <= sec1_d;
      sec2_q <= sec2_d;
    end
  end

  assign min1 = min1_q;
  assign min2 = min2_q;
  assign sec1 = sec1_q;
  assign sec2 = sec2_q;

  // ---------------------------------------------------------------------------
  // Display scan and blink
  // ---------------------------------------------------------------------------
  logic [1:0] scan_idx_q, scan_idx_d;
  logic       blink_q, blink_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] dig_q, dig_d;
  logic [3:0] digit_val;

  assign scan_idx_d = scan_idx_q + {1'b0, tick_scan};
  assign blink_d    = blink_q ^ tick_blink;

  always_comb begin
    dig_d     = 4'b1110;
    digit_val = sec2_q;
    case (scan_idx_q)
      2'd0: begin
        dig_d     = 4'b1110;
        digit_val = sec2_q;
      end
      2'd1: begin
        dig_d     = 4'b1101;
        digit_val = {1'b0, sec1_q};
      end
      2'd2: begin
        dig_d     = 4'b1011;
        digit_val = min2_q;
      end
      default: begin
        dig_d     = 4'b0111;
        digit_val = {1'b0, min1_q};
      end
    endcase

    // Blank the pair being adjusted during the on-phase of the blink.
    if (adj_s && blink_q) begin
      if (sel_s) begin
        dig_d[1:0] = 2'b11;
      end else begin
        dig_d[3:2] = 2'b11;
      end
    end

    // Active-low, bit order g..a
    case (digit_val)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx_q <= 2'd0;
      blink_q    <= 1'b0;
      seg_q      <= 7'b1000000;
      dig_q      <= 4'b1110;
    end else begin
      scan_idx_q <= scan_idx_d;
      blink_q    <= blink_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule

// File: tb/tb_stopwatch_top.sv
`timescale 1ns/1ps
// Directed bench for stopwatch_top with shortened dividers:
// ONE_HZ_DIV=10, TWO_HZ_DIV=5, SCAN_DIV=2, BLINK_DIV=8, 2 ns clock.
module tb_stopwatch_top;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] min1;
  logic [3:0] min2;
  logic [2:0] sec1;
  logic [3:0] sec2;
  logic [6:0] seg;
  logic [3:0] dig;

  int checks = 0;
  int errors = 0;

  logic [13:0] now_t;
  assign now_t = {min1, min2, sec1, sec2};

  always #1 clk = ~clk;

  stopwatch_top #(
    .ONE_HZ_DIV (10),
    .TWO_HZ_DIV (5),
    .SCAN_DIV   (2),
    .BLINK_DIV  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .adj   (adj),
    .sel   (sel),
    .min1  (min1),
    .min2  (min2),
    .sec1  (sec1),
    .sec2  (sec2),
    .seg   (seg),
    .dig   (dig)
  );

  // Packed MM:SS in the same layout as now_t
  function automatic logic [13:0] mmss(int m, int s);
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  // Expected active-low pattern (g..a) for a decimal digit
  function automatic logic [6:0] pat(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Advance n rising edges, land on the following falling edge (n >= 1).
  task automatic adv(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse; returns on the falling edge where reset is released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pause = 1'b0;
    adj   = 1'b0;
    sel   = 1'b0;
    adv(3);
    reset = 1'b0;
  endtask

  // Hold adj high for exactly 5*n cycles, giving exactly n adjust ticks.
  task automatic adj_ticks(logic s, int n);
    sel = s;
    adv(3);
    adj = 1'b1;
    adv(5 * n);
    adj = 1'b0;
    adv(3);
  endtask

  task automatic test_reset();
    logic [3:0] exp_dig [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                4'b1011, 4'b1011, 4'b0111, 4'b0111};
    @(negedge clk);
    reset = 1'b1;
    adv(2);
    checks++;
    if (now_t !== mmss(0, 0)) begin
      errors++;
      $display("FAIL reset_time got %0d%0d:%0d%0d exp 00:00", min1, min2, sec1, sec2);
    end
    checks++;
    if (dig !== 4'b1110) begin
      errors++;
      $display("FAIL reset_dig got %b exp 1110", dig);
    end
    checks++;
    if (seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_seg got %b exp 1000000", seg);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      adv(1);
      checks++;
      if (dig !== exp_dig[i] || seg !== 7'b1000000) begin
        errors++;
        $display("FAIL reset_scan%0d got dig %b seg %b exp dig %b seg 1000000",
                 i, dig, seg, exp_dig[i]);
      end
    end
    adv(91);
    checks++;
    if (now_t !== mmss(0, 9)) begin
      errors++;
      $display("FAIL run_99 got %0d%0d:%0d%0d exp 00:09", min1, min2, sec1, sec2);
    end
    adv(1);
    checks++;
    if (now_t !== mmss(0, 10)) begin
      errors++;
      $display("FAIL run_100 got %0d%0d:%0d%0d exp 00:10", min1, min2, sec1, sec2);
    end
  endtask

  task automatic test_carry();
    int at_cyc [6] = '{590, 600, 5990, 6000, 35990, 36000};
    int exp_m  [6] = '{0, 1, 9, 10, 59, 0};
    int exp_s  [6] = '{59, 0, 59, 0, 59, 0};
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      adv(at_cyc[i] - cyc);
      cyc = at_cyc[i];
      checks++;
      if (now_t !== mmss(exp_m[i], exp_s[i])) begin
        errors++;
        $display("FAIL carry_%0d got %0d%0d:%0d%0d exp %02d:%02d",
                 cyc, min1, min2, sec1, sec2, exp_m[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_pause();
    int cyc_at [6] = '{29, 30, 250, 259, 260, 300};
    int exp_s  [6] = '{2, 3, 3, 3, 4, 8};
    do_reset();
    adv(27);
    pause = 1'b1;               // toggle lands on edge 30, same as a 1 Hz tick
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: adv(2);
        1: adv(1);
        2: begin
          adv(17);
          pause = 1'b0;         // held 20 cycles: must toggle only once
          adv(203);
        end
        3: begin
          pause = 1'b1;         // second press, toggle on edge 253
          adv(5);
          pause = 1'b0;
          adv(4);
        end
        4: adv(1);
        default: adv(40);
      endcase
      checks++;
      if (now_t !== mmss(0, exp_s[i])) begin
        errors++;
        $display("FAIL pause_%0d got %0d%0d:%0d%0d exp 00:%02d",
                 cyc_at[i], min1, min2, sec1, sec2, exp_s[i]);
      end
    end
  endtask

  task automatic test_adjust();
    logic       tgt   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int         ticks [6] = '{59, 58, 2, 5, 1, 0};
    int         exp_m [6] = '{59, 59, 59, 59, 0, 0};
    int         exp_s [6] = '{0, 58, 0, 5, 5, 5};
    // Hold the counter first so only adjust ticks move the digits.
    do_reset();
    pause = 1'b1;
    adv(2);
    pause = 1'b0;
    adv(4);
    for (int i = 0; i < 6; i++) begin
      if (ticks[i] > 0) begin
        adj_ticks(tgt[i], ticks[i]);
      end else begin
        adv(200);               // still held after leaving adjust mode
      end
      checks++;
      if (now_t !== mmss(exp_m[i], exp_s[i])) begin
        errors++;
        $display("FAIL adjust_%0d got %0d%0d:%0d%0d exp %02d:%02d",
                 i, min1, min2, sec1, sec2, exp_m[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_blink();
    int n_blank;
    int n_min;
    int n_sec;
    // Without adjust, minutes show half the time and nothing is blanked.
    n_blank = 0;
    n_min   = 0;
    for (int i = 0; i < 16; i++) begin
      if (dig == 4'b1111) n_blank++;
      if (dig == 4'b0111 || dig == 4'b1011) n_min++;
      adv(1);
    end
    checks++;
    if (n_blank != 0 || n_min != 8) begin
      errors++;
      $display("FAIL noblink got blank %0d min %0d exp blank 0 min 8", n_blank, n_min);
    end
    // adj=1, sel=0: in any 16 cycles, blink phase 1 covers half the minute slots.
    sel = 1'b0;
    adv(3);
    adj = 1'b1;
    adv(3);
    n_blank = 0;
    n_min   = 0;
    n_sec   = 0;
    for (int i = 0; i < 16; i++) begin
      if (dig == 4'b1111) n_blank++;
      if (dig == 4'b0111 || dig == 4'b1011) n_min++;
      if (dig == 4'b1110 || dig == 4'b1101) n_sec++;
      adv(1);
    end
    adv(1);
    adj = 1'b0;                 // adj was high 20 cycles: 4 minute ticks
    adv(3);
    checks++;
    if (n_blank != 4) begin
      errors++;
      $display("FAIL blink_blank got %0d exp 4", n_blank);
    end
    checks++;
    if (n_min != 4 || n_sec != 8) begin
      errors++;
      $display("FAIL blink_scan got min %0d sec %0d exp min 4 sec 8", n_min, n_sec);
    end
    checks++;
    if (now_t !== mmss(4, 5)) begin
      errors++;
      $display("FAIL blink_time got %0d%0d:%0d%0d exp 04:05", min1, min2, sec1, sec2);
    end
  endtask

  task automatic test_scan();
    logic [3:0] seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int         dval [4] = '{4, 3, 2, 1};     // digits of 12:34
    logic [3:0] prev;
    int         start;
    bit         found;
    adj_ticks(1'b0, 8);
    adj_ticks(1'b1, 29);
    checks++;
    if (now_t !== mmss(12, 34)) begin
      errors++;
      $display("FAIL preset got %0d%0d:%0d%0d exp 12:34", min1, min2, sec1, sec2);
    end
    // Align to the first cycle of a digit slot.
    prev  = dig;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      adv(1);
      if (dig != prev) found = 1'b1;
    end
    start = -1;
    for (int j = 0; j < 4; j++) begin
      if (dig == seq[j]) start = j;
    end
    checks++;
    if (!found || start < 0) begin
      errors++;
      $display("FAIL scan_align got dig %b exp a slot change to a one-hot-low anode", dig);
    end else begin
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (start + i / 2) % 4;
        checks++;
        if (dig !== seq[k] || seg !== pat(dval[k])) begin
          errors++;
          $display("FAIL scan_%0d got dig %b seg %b exp dig %b seg %b",
                   i, dig, seg, seq[k], pat(dval[k]));
        end
        adv(1);
      end
    end
  endtask

  task automatic test_reset_midop();
    sel = 1'b1;
    adj = 1'b1;
    adv(4);
    reset = 1'b1;
    #0.5;
    checks++;
    if (now_t !== mmss(0, 0) || seg !== 7'b1000000 || dig !== 4'b1110) begin
      errors++;
      $display("FAIL midop_reset got %0d%0d:%0d%0d seg %b dig %b exp 00:00 seg 1000000 dig 1110",
               min1, min2, sec1, sec2, seg, dig);
    end
    adj = 1'b0;
    sel = 1'b0;
    adv(2);
    reset = 1'b0;
    adv(9);
    checks++;
    if (now_t !== mmss(0, 0)) begin
      errors++;
      $display("FAIL midop_9 got %0d%0d:%0d%0d exp 00:00", min1, min2, sec1, sec2);
    end
    adv(1);
    checks++;
    if (now_t !== mmss(0, 1)) begin
      errors++;
      $display("FAIL midop_unpaused got %0d%0d:%0d%0d exp 00:01", min1, min2, sec1, sec2);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_pause();
    test_adjust();
    test_blink();
    test_scan();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
